// File: rtl/multdiv_sequencer.sv
// Iterative signed multiply (radix-2 Booth) / divide (non-restoring) sequencer, WIDTH iterations per op.
// Optional MULTDIV_REMAINDER_EN adds the data_remainder output for divides.
module multdiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
`ifdef MULTDIV_REMAINDER_EN
    ,
    output logic [WIDTH-1:0] data_remainder
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand;      // multiplicand, or divisor magnitude
    logic [WIDTH:0]   acc;        // product high half, or partial remainder
    logic [WIDTH-1:0] lo;         // multiplier/product low half, or dividend/quotient
    logic             booth_q;
    logic             op_div;
    logic             div_zero;
    logic             div_exc;
    logic             neg_q;
`ifdef MULTDIV_REMAINDER_EN
    logic             neg_r;
    logic [WIDTH-1:0] rem_low;
    logic [WIDTH-1:0] rem_fix;
`endif

    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_next;
    logic [WIDTH:0]   mul_hi;
    logic             mul_ovf;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    // Accumulator carries a guard bit so the most-negative multiplicand stays exact.
    always_comb begin
        booth_sum = acc;
        case ({lo[0], booth_q})
            2'b01:   booth_sum = acc + {mcand[WIDTH-1], mcand};
            2'b10:   booth_sum = acc - {mcand[WIDTH-1], mcand};
            default: booth_sum = acc;
        endcase
        div_shift = {acc[WIDTH-1:0], lo[WIDTH-1]};
        div_next  = acc[WIDTH] ? (div_shift + {1'b0, mcand}) : (div_shift - {1'b0, mcand});
        mul_hi    = {acc[WIDTH-1:0], lo[WIDTH-1]};
        mul_ovf   = ~((&mul_hi) | ~(|mul_hi));
        quot_fix  = neg_q ? ((~lo) + WIDTH'(1)) : lo;
        abs_a     = data_operandA[WIDTH-1] ? ((~data_operandA) + WIDTH'(1)) : data_operandA;
        abs_b     = data_operandB[WIDTH-1] ? ((~data_operandB) + WIDTH'(1)) : data_operandB;
    end

`ifdef MULTDIV_REMAINDER_EN
    // Final restore step then apply the dividend's sign.
    always_comb begin
        rem_low = acc[WIDTH-1:0] + (acc[WIDTH] ? mcand : '0);
        rem_fix = neg_r ? ((~rem_low) + WIDTH'(1)) : rem_low;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            mcand          <= '0;
            acc            <= '0;
            lo             <= '0;
            booth_q        <= 1'b0;
            op_div         <= 1'b0;
            div_zero       <= 1'b0;
            div_exc        <= 1'b0;
            neg_q          <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
            neg_r          <= 1'b0;
            data_remainder <= '0;
`endif
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                S_MULT: begin
                    acc     <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    lo      <= {booth_sum[0], lo[WIDTH-1:1]};
                    booth_q <= lo[0];
                    cnt     <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= S_DONE;
                end
                S_DIV: begin
                    acc <= div_next;
                    lo  <= {lo[WIDTH-2:0], ~div_next[WIDTH]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= S_DONE;
                end
                S_DONE: begin
                    state          <= S_IDLE;
                    busy           <= 1'b0;
                    data_resultRDY <= 1'b1;
                    cnt            <= '0;
                    if (!op_div) begin
                        data_result    <= lo;
                        data_exception <= mul_ovf;
                    end else if (div_zero) begin
                        data_result    <= '0;
                        data_exception <= 1'b1;
`ifdef MULTDIV_REMAINDER_EN
                        data_remainder <= lo;
`endif
                    end else begin
                        data_result    <= quot_fix;
                        data_exception <= div_exc;
`ifdef MULTDIV_REMAINDER_EN
                        data_remainder <= rem_fix;
`endif
                    end
                end
                default: ;
            endcase

            // A start pulse always wins: it aborts any op in flight and relaunches.
            if (ctrl_MULT || ctrl_DIV) begin
                busy     <= 1'b1;
                cnt      <= '0;
                acc      <= '0;
                booth_q  <= 1'b0;
                div_zero <= 1'b0;
                if (ctrl_MULT) begin
                    state  <= S_MULT;
                    op_div <= 1'b0;
                    mcand  <= data_operandA;
                    lo     <= data_operandB;
                end else begin
                    op_div  <= 1'b1;
                    mcand   <= abs_b;
                    neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    div_exc <= (data_operandB == '0) ||
                               ((data_operandA == MIN_VAL) && (&data_operandB));
`ifdef MULTDIV_REMAINDER_EN
                    neg_r   <= data_operandA[WIDTH-1];
`endif
                    if (data_operandB == '0) begin
                        state    <= S_DONE;
                        div_zero <= 1'b1;
                        lo       <= data_operandA;
                    end else begin
                        state <= S_DIV;
                        lo    <= abs_a;
                    end
                end
            end
        end
    end

endmodule
